// File: rtl/axi3_slave_write.sv
// axi3_slave_write: AXI3 write-channel slave that stores bursts into a byte-addressed register memory
module axi3_slave_write #(
  parameter int DATAWIDTH = 32,
  parameter int SIZE      = 3,
  parameter int MEMBYTES  = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATAWIDTH/8-1:0]        AWid,
  input  logic [DATAWIDTH-1:0]          AWaddr,
  input  logic [DATAWIDTH/8-1:0]        AWlen,
  input  logic [SIZE-1:0]               AWsize,
  input  logic [SIZE-2:0]               AWburst,
  input  logic                          AWvalid,
  output logic                          AWready,
  input  logic [DATAWIDTH-1:0]          WData,
  input  logic [DATAWIDTH/8-1:0]        WStrb,
  input  logic [DATAWIDTH/8-1:0]        Wid,
  input  logic                          Wlast,
  input  logic                          Wvalid,
  output logic                          Wready,
  output logic [DATAWIDTH/8-1:0]        Bid,
  output logic [1:0]                    Bresp,
  output logic                          Bvalid,
  input  logic                          Bready,
  output logic [MEMBYTES-1:0][7:0]      write_memory
);
  localparam int NB = DATAWIDTH / 8;
  localparam int AW = $clog2(MEMBYTES);
  localparam int LS = $clog2(NB);

  typedef enum logic [1:0] {SWRITE_IDLE, SWRITE_DATA, SWRITE_RESP} state_t;

  state_t               r_state;
  logic [NB-1:0]        r_id;
  logic [DATAWIDTH-1:0] r_addr;
  logic [NB-1:0]        r_len;
  logic [SIZE-1:0]      r_size;
  logic [SIZE-2:0]      r_burst;
  logic [3:0]           r_cnt;
  logic                 r_err;
  logic                 r_awerr;
  logic [DATAWIDTH-1:0] r_wlo;
  logic [DATAWIDTH-1:0] r_whi;

  logic [DATAWIDTH-1:0] w_awbpb, w_wsz, w_wlo;
  logic                 w_awerr;
  logic                 w_beat, w_oor, w_idbad, w_atlen, w_lasterr, w_berr, w_wr, w_end_burst;
  logic [DATAWIDTH-1:0] w_align, w_bpb, w_incr, w_next;
  logic [DATAWIDTH:0]   w_end;
  logic [NB-1:0]        w_cnt;
  logic [AW-1:0]        w_idx;

  // Address-phase decode: wrap window and protocol errors detected before any data arrives
  always_comb begin
    w_awbpb = DATAWIDTH'(1) << AWsize;
    w_wsz   = w_awbpb * (DATAWIDTH'(AWlen) + DATAWIDTH'(1));
    w_wlo   = AWaddr & ~(w_wsz - DATAWIDTH'(1));
    w_awerr = (&AWburst) || (AWsize > SIZE'(LS)) ||
              ((AWburst == (SIZE-1)'(2)) && !(AWlen == NB'(1) || AWlen == NB'(3) ||
                                              AWlen == NB'(7) || AWlen == NB'(15)));
  end

  // Data-phase decode: per-beat checks, write enable and next beat address
  always_comb begin
    w_beat      = (r_state == SWRITE_DATA) && Wvalid && Wready;
    w_align     = r_addr & ~DATAWIDTH'(NB - 1);
    w_end       = {1'b0, w_align} + (DATAWIDTH+1)'(NB);
    w_oor       = w_end > (DATAWIDTH+1)'(MEMBYTES);
    w_idbad     = Wid != r_id;
    w_cnt       = NB'(r_cnt);
    w_atlen     = w_cnt == r_len;
    w_lasterr   = Wlast ? (w_cnt < r_len) : w_atlen;
    w_berr      = w_oor || w_idbad || w_lasterr;
    w_wr        = w_beat && !r_awerr && !w_oor && !w_idbad;
    w_end_burst = Wlast || w_atlen;
    w_idx       = w_align[AW-1:0];
    w_bpb       = DATAWIDTH'(1) << r_size;
    w_incr      = (r_addr & ~(w_bpb - DATAWIDTH'(1))) + w_bpb;
    w_next      = (r_burst == '0) ? r_addr :
                  ((r_burst == (SIZE-1)'(2)) && (w_incr >= r_whi)) ? r_wlo : w_incr;
  end

  // Burst FSM with registered handshake outputs; one burst in flight at a time
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SWRITE_IDLE;
      AWready <= 1'b1;
      Wready  <= 1'b0;
      Bvalid  <= 1'b0;
      Bid     <= '0;
      Bresp   <= 2'b00;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_awerr <= 1'b0;
      r_wlo   <= '0;
      r_whi   <= '0;
    end else begin
      case (r_state)
        SWRITE_IDLE: if (AWvalid && AWready) begin
          r_id    <= AWid;
          r_addr  <= AWaddr;
          r_len   <= AWlen;
          r_size  <= AWsize;
          r_burst <= AWburst;
          r_cnt   <= '0;
          r_err   <= w_awerr;
          r_awerr <= w_awerr;
          r_wlo   <= w_wlo;
          r_whi   <= w_wlo + w_wsz;
          AWready <= 1'b0;
          Wready  <= 1'b1;
          r_state <= SWRITE_DATA;
        end
        SWRITE_DATA: if (w_beat) begin
          r_addr <= w_next;
          r_cnt  <= r_cnt + 4'd1;
          if (w_berr) r_err <= 1'b1;
          if (w_end_burst) begin
            Wready  <= 1'b0;
            Bvalid  <= 1'b1;
            Bid     <= r_id;
            Bresp   <= (r_err || w_berr) ? 2'b10 : 2'b00;
            r_state <= SWRITE_RESP;
          end
        end
        SWRITE_RESP: if (Bready) begin
          Bvalid  <= 1'b0;
          AWready <= 1'b1;
          r_state <= SWRITE_IDLE;
        end
        default: r_state <= SWRITE_IDLE;
      endcase
    end
  end

  // Byte-lane writes into the target memory, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) write_memory <= '0;
    else if (w_wr)
      for (int i = 0; i < NB; i++)
        if (WStrb[i]) write_memory[w_idx + AW'(i)] <= WData[8*i +: 8];
  end
endmodule

// File: tb/tb_axi3_slave_write.sv
// tb_axi3_slave_write: randomized and directed bursts checked against a behavioural byte-memory model
module tb_axi3_slave_write;
  localparam int MB = 4096;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  AWid, AWlen, WStrb, Wid, Bid;
  logic [31:0] AWaddr, WData;
  logic [2:0]  AWsize;
  logic [1:0]  AWburst, Bresp;
  logic        AWvalid, AWready, Wlast, Wvalid, Wready, Bvalid, Bready;
  logic [MB-1:0][7:0] write_memory;

  axi3_slave_write #(.DATAWIDTH(32), .SIZE(3), .MEMBYTES(MB)) dut (
    .clk(clk), .rst(rst), .AWid(AWid), .AWaddr(AWaddr), .AWlen(AWlen), .AWsize(AWsize),
    .AWburst(AWburst), .AWvalid(AWvalid), .AWready(AWready), .WData(WData), .WStrb(WStrb),
    .Wid(Wid), .Wlast(Wlast), .Wvalid(Wvalid), .Wready(Wready), .Bid(Bid), .Bresp(Bresp),
    .Bvalid(Bvalid), .Bready(Bready), .write_memory(write_memory));

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_mem [MB];
  logic [3:0]  a_id, a_len;
  logic [31:0] a_addr;
  logic [2:0]  a_size;
  logic [1:0]  a_burst;
  logic [31:0] b_data [16];
  logic [3:0]  b_strb [16];
  logic [3:0]  b_wid  [16];
  logic        b_last [16];
  int          exp_nb;
  logic [1:0]  exp_resp;

  function automatic int beat_addr(int n);
    int bpb, al, wsz, lo;
    bpb = 1 << a_size;
    al  = (int'(a_addr) / bpb) * bpb;
    wsz = bpb * (int'(a_len) + 1);
    lo  = (int'(a_addr) / wsz) * wsz;
    if (n == 0 || a_burst == 2'd0) return int'(a_addr);
    if (a_burst == 2'd2) return lo + (al - lo + n * bpb) % wsz;
    return al + n * bpb;
  endfunction

  task automatic model();
    bit awerr, err, oor, idb;
    int a, base;
    awerr = a_burst == 2'd3 || a_size > 3'd2 || (a_burst == 2'd2 && !(a_len inside {4'd1, 4'd3, 4'd7, 4'd15}));
    err = awerr;
    exp_nb = 16;
    for (int n = 0; n < 16; n++) begin
      a = beat_addr(n);
      base = (a / 4) * 4;
      oor = base + 4 > MB;
      idb = b_wid[n] != a_id;
      if (oor || idb || (b_last[n] && n < int'(a_len)) || (!b_last[n] && n == int'(a_len))) err = 1;
      if (!awerr && !oor && !idb)
        for (int i = 0; i < 4; i++) if (b_strb[n][i]) exp_mem[base + i] = b_data[n][8*i +: 8];
      if (b_last[n] || n == int'(a_len)) begin exp_nb = n + 1; break; end
    end
    exp_resp = err ? 2'b10 : 2'b00;
  endtask

  task automatic default_beats();
    for (int n = 0; n < 16; n++) begin
      b_data[n] = $urandom;
      b_strb[n] = 4'hF;
      b_wid[n]  = a_id;
      b_last[n] = (n == int'(a_len));
    end
  endtask

  task automatic check_mem(string name);
    int bad = -1;
    for (int i = 0; i < MB; i++) if (bad < 0 && write_memory[i] !== exp_mem[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s mem[0x%0h] got %02h expected %02h", name, bad, write_memory[bad], exp_mem[bad]);
    end
  endtask

  task automatic send_aw(string name);
    int t = 0;
    @(negedge clk);
    AWid = a_id; AWaddr = a_addr; AWlen = a_len; AWsize = a_size; AWburst = a_burst; AWvalid = 1'b1;
    while (!AWready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin checks++; errors++; $display("FAIL %s aw_timeout got AWready=0 expected 1", name); end
    @(posedge clk); #1 AWvalid = 1'b0;
  endtask

  task automatic send_beats(string name);
    for (int n = 0; n < exp_nb; n++) begin
      int t = 0;
      repeat ($urandom_range(0, 1)) @(negedge clk);
      @(negedge clk);
      WData = b_data[n]; WStrb = b_strb[n]; Wid = b_wid[n]; Wlast = b_last[n]; Wvalid = 1'b1;
      while (!Wready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin checks++; errors++; $display("FAIL %s w_timeout beat %0d got Wready=0 expected 1", name, n); end
      @(posedge clk); #1 Wvalid = 1'b0;
    end
  endtask

  task automatic get_b(string name, int bp);
    int t = 0;
    logic [3:0] cid;
    logic [1:0] crsp;
    @(negedge clk);
    Bready = 1'b0;
    while (!Bvalid && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin checks++; errors++; $display("FAIL %s b_timeout got Bvalid=0 expected 1", name); end
    cid = Bid; crsp = Bresp;
    AWvalid = (bp > 0);
    for (int c = 0; c < bp; c++) begin
      checks++;
      if (Bvalid !== 1'b1 || Bid !== cid || Bresp !== crsp || AWready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold cycle %0d got V=%b id=%h resp=%b awr=%b expected V=1 id=%h resp=%b awr=0",
                 name, c, Bvalid, Bid, Bresp, AWready, cid, crsp);
      end
      @(negedge clk);
    end
    AWvalid = 1'b0;
    Bready = 1'b1;
    checks++;
    if (Bid !== a_id) begin errors++; $display("FAIL %s bid got %h expected %h", name, Bid, a_id); end
    checks++;
    if (Bresp !== exp_resp) begin errors++; $display("FAIL %s bresp got %b expected %b", name, Bresp, exp_resp); end
    @(posedge clk); #1 Bready = 1'b0;
    @(negedge clk);
    checks++;
    if (Bvalid !== 1'b0 || AWready !== 1'b1) begin
      errors++; $display("FAIL %s post_b got V=%b awr=%b expected V=0 awr=1", name, Bvalid, AWready);
    end
    check_mem(name);
  endtask

  task automatic run(string name, int bp);
    model();
    send_aw(name);
    send_beats(name);
    get_b(name, bp);
  endtask

  task automatic check_byte(string name, int addr, logic [7:0] v);
    checks++;
    if (write_memory[addr] !== v) begin
      errors++; $display("FAIL %s byte[0x%0h] got %02h expected %02h", name, addr, write_memory[addr], v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (AWready !== 1'b1 || Wready !== 1'b0 || Bvalid !== 1'b0 || Bid !== 4'h0 || Bresp !== 2'b00) begin
      errors++;
      $display("FAIL reset got awr=%b wr=%b bv=%b bid=%h bresp=%b expected 1 0 0 0 00",
               AWready, Wready, Bvalid, Bid, Bresp);
    end
    check_mem("reset");
    rst = 1'b0;
  endtask

  task automatic test_incr();
    a_id = 4'h5; a_addr = 32'h10; a_len = 4'd3; a_size = 3'd2; a_burst = 2'd1;
    default_beats();
    for (int n = 0; n < 4; n++) b_data[n] = 32'h11111111 * (n + 1);
    run("incr", 0);
    check_byte("incr", 'h10, 8'h11);
    check_byte("incr", 'h1F, 8'h44);
  endtask

  task automatic test_wrap();
    a_id = 4'h9; a_addr = 32'h38; a_len = 4'd3; a_size = 3'd2; a_burst = 2'd2;
    default_beats();
    for (int n = 0; n < 4; n++) b_data[n] = {4{8'(8'hA0 + n)}};
    run("wrap", 0);
    check_byte("wrap", 'h38, 8'hA0);
    check_byte("wrap", 'h3C, 8'hA1);
    check_byte("wrap", 'h30, 8'hA2);
    check_byte("wrap", 'h34, 8'hA3);
  endtask

  task automatic test_fixed();
    a_id = 4'h2; a_addr = 32'h100; a_len = 4'd1; a_size = 3'd2; a_burst = 2'd0;
    default_beats();
    b_data[0] = 32'h11223344; b_strb[0] = 4'b0001;
    b_data[1] = 32'h55667788; b_strb[1] = 4'b0010;
    run("fixed", 0);
    check_byte("fixed", 'h100, 8'h44);
    check_byte("fixed", 'h101, 8'h77);
    check_byte("fixed", 'h102, 8'h00);
  endtask

  task automatic test_errors();
    a_id = 4'h3; a_addr = 32'hFFC; a_len = 4'd1; a_size = 3'd2; a_burst = 2'd1;
    default_beats();
    b_data[0] = 32'hCAFEF00D;
    run("err_range", 0);
    check_byte("err_range", 'hFFC, 8'h0D);
    a_id = 4'h4; a_addr = 32'h200; a_len = 4'd1; a_burst = 2'd3;
    default_beats();
    run("err_burst", 0);
    a_id = 4'h6; a_addr = 32'h300; a_len = 4'd3; a_burst = 2'd1;
    default_beats();
    b_last[1] = 1'b1;
    run("err_early_last", 0);
    a_id = 4'h7; a_addr = 32'h400; a_len = 4'd1;
    default_beats();
    b_wid[1] = 4'h8;
    run("err_wid", 0);
    a_id = 4'hA; a_addr = 32'h480; a_len = 4'd2; a_burst = 2'd2;
    default_beats();
    run("err_wraplen", 0);
    a_id = 4'hB; a_addr = 32'h4C0; a_len = 4'd0; a_size = 3'd3; a_burst = 2'd1;
    default_beats();
    run("err_size", 0);
  endtask

  task automatic test_backpressure();
    a_id = 4'hC; a_addr = 32'h600; a_len = 4'd2; a_size = 3'd2; a_burst = 2'd1;
    default_beats();
    run("backpressure", 5);
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      a_id = 4'($urandom); a_addr = 32'($urandom_range(0, MB - 1));
      a_size = 3'($urandom_range(0, 2)); a_burst = 2'($urandom_range(0, 2));
      a_len = (a_burst == 2'd2) ? 4'((1 << $urandom_range(1, 4)) - 1) : 4'($urandom);
      default_beats();
      for (int n = 0; n < 16; n++) begin
        b_strb[n] = 4'($urandom);
        if ($urandom_range(0, 15) == 0) b_wid[n] = ~a_id;
      end
      if ($urandom_range(0, 5) == 0) b_last[$urandom_range(0, 15)] = 1'b1;
      run("random", $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_midburst();
    a_id = 4'hD; a_addr = 32'h500; a_len = 4'd3; a_size = 3'd2; a_burst = 2'd1;
    default_beats();
    exp_nb = 1;
    send_aw("rst_mid");
    send_beats("rst_mid");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < MB; i++) exp_mem[i] = 8'h00;
    @(negedge clk);
    checks++;
    if (AWready !== 1'b1 || Wready !== 1'b0 || Bvalid !== 1'b0) begin
      errors++; $display("FAIL rst_mid got awr=%b wr=%b bv=%b expected 1 0 0", AWready, Wready, Bvalid);
    end
    check_mem("rst_mid");
    repeat (3) @(negedge clk);
    checks++;
    if (Bvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_nob got Bvalid=%b expected 0", Bvalid); end
  endtask

  initial begin
    AWid = '0; AWaddr = '0; AWlen = '0; AWsize = '0; AWburst = '0; AWvalid = 1'b0;
    WData = '0; WStrb = '0; Wid = '0; Wlast = 1'b0; Wvalid = 1'b0; Bready = 1'b0;
    for (int i = 0; i < MB; i++) exp_mem[i] = 8'h00;
    test_reset();
    test_incr();
    test_wrap();
    test_fixed();
    test_errors();
    test_backpressure();
    test_random();
    test_reset_midburst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
